// File: rtl/amadeus_pkg.sv
// Shared types and defaults for the Amadeus accelerator datapath blocks.
package amadeus_pkg;

    localparam int unsigned IFMAP_DATA_W = 64;
    localparam int unsigned IFMAP_DEPTH  = 256;

    // Per-bank occupancy of the ifmap ping-pong buffer.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

endpackage

// File: rtl/ifmap_pingpong_buffer_if.sv
// Loader write stream, PE-array read port and bank-release handshake of the ifmap buffer.
interface ifmap_pingpong_buffer_if
    import amadeus_pkg::*;
#(
    parameter int unsigned DATA_W = IFMAP_DATA_W,
    parameter int unsigned DEPTH  = IFMAP_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
);

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              ifmap_ready;
    logic              rd_bank;
    logic [ADDR_W:0]   rd_len;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              free_ifmap_buffer;
    logic              err;

    // Loader plus PE-array controller side.
    modport master (
        output wr_valid, wr_data, wr_last, rd_en, rd_addr, free_ifmap_buffer,
        input  wr_ready, ifmap_ready, rd_bank, rd_len, rd_data, rd_valid, err
    );

    // Buffer side.
    modport slave (
        input  wr_valid, wr_data, wr_last, rd_en, rd_addr, free_ifmap_buffer,
        output wr_ready, ifmap_ready, rd_bank, rd_len, rd_data, rd_valid, err
    );

endinterface

// File: rtl/ifmap_bank_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port with 1-cycle latency.
module ifmap_bank_ram
    import amadeus_pkg::*;
#(
    parameter int unsigned DATA_W = IFMAP_DATA_W,
    parameter int unsigned DEPTH  = 2 * IFMAP_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ifmap_pingpong_buffer.sv
// Ping-pong ifmap buffer: the loader fills one bank while the PE array reads the other.
module ifmap_pingpong_buffer
    import amadeus_pkg::*;
#(
    parameter int unsigned DATA_W = IFMAP_DATA_W,
    parameter int unsigned DEPTH  = IFMAP_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input logic                    clk,
    input logic                    rst,
    ifmap_pingpong_buffer_if.slave bus
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    bank_state_e       state_q [2];
    bank_state_e       state_d [2];
    logic [LEN_W-1:0]  len_q   [2];
    logic [LEN_W-1:0]  len_d   [2];
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              err_q, err_d;
    logic              rd_valid_q, rd_err_q;

    logic              wr_ready;
    logic              wr_accept;
    logic              wr_close;
    logic              rd_ready;
    logic              rd_bad;
    logic              free_ok;
    logic [DATA_W-1:0] ram_rdata;

    assign wr_ready  = !rst && (state_q[wr_bank_q] != FULL);
    assign wr_accept = bus.wr_valid && wr_ready;
    assign wr_close  = wr_accept && (bus.wr_last || (wr_ptr_q == ADDR_W'(DEPTH - 1)));
    assign rd_ready  = (state_q[rd_bank_q] == FULL);
    assign free_ok   = bus.free_ifmap_buffer && rd_ready;
    assign rd_bad    = bus.rd_en && (!rd_ready || ({1'b0, bus.rd_addr} >= len_q[rd_bank_q]));

    // Write and free never target the same bank: a FULL write bank blocks writes,
    // and only a FULL read bank can be freed.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        wr_ptr_d  = wr_ptr_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        err_d     = err_q || (bus.free_ifmap_buffer && !rd_ready) || rd_bad;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (state_q[wr_bank_q] == EMPTY) begin
                state_d[wr_bank_q] = FILLING;
            end
            if (wr_close) begin
                state_d[wr_bank_q] = FULL;
                len_d[wr_bank_q]   = {1'b0, wr_ptr_q} + LEN_W'(1);
                wr_ptr_d           = '0;
                wr_bank_d          = !wr_bank_q;
            end
        end

        if (free_ok) begin
            state_d[rd_bank_q] = EMPTY;
            rd_bank_d          = !rd_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
            len_q[0]   <= '0;
            len_q[1]   <= '0;
            wr_ptr_q   <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            len_q[0]   <= len_d[0];
            len_q[1]   <= len_d[1];
            wr_ptr_q   <= wr_ptr_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            err_q      <= err_d;
            rd_valid_q <= bus.rd_en;
            rd_err_q   <= rd_bad;
        end
    end

    // Both banks share one RAM, addressed by {bank, word}.
    ifmap_bank_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (2 * DEPTH),
        .ADDR_W (ADDR_W + 1)
    ) u_ram (
        .clk   (clk),
        .we    (wr_accept),
        .waddr ({wr_bank_q, wr_ptr_q}),
        .wdata (bus.wr_data),
        .re    (bus.rd_en),
        .raddr ({rd_bank_q, bus.rd_addr}),
        .rdata (ram_rdata)
    );

    assign bus.wr_ready    = wr_ready;
    assign bus.ifmap_ready = rd_ready;
    assign bus.rd_bank     = rd_bank_q;
    assign bus.rd_len      = len_q[rd_bank_q];
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = (rd_valid_q && !rd_err_q) ? ram_rdata : '0;
    assign bus.err         = err_q;

endmodule
